// File: rtl/decode_stage_pkg.sv
// Shared types for the decode stage: opcode map, one-hot instruction classes
// and the decoded packet handed to issue.
package decode_stage_pkg;

    localparam int XLEN_MAX = 64;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_FENCE     = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    // CLS_NONE marks an illegal packet; every legal class is a single bit.
    typedef enum logic [12:0] {
        CLS_NONE   = 13'h0000,
        CLS_R      = 13'h0001,
        CLS_I      = 13'h0002,
        CLS_L      = 13'h0004,
        CLS_S      = 13'h0008,
        CLS_B      = 13'h0010,
        CLS_U      = 13'h0020,
        CLS_AUIPC  = 13'h0040,
        CLS_JAL    = 13'h0080,
        CLS_JALR   = 13'h0100,
        CLS_SYSTEM = 13'h0200,
        CLS_FENCE  = 13'h0400,
        CLS_R64    = 13'h0800,
        CLS_I64    = 13'h1000
    } instr_class_e;

    typedef logic [3:0] access_size_t;

    localparam access_size_t SZ_NONE = 4'b0000;
    localparam access_size_t SZ_B    = 4'b0001;
    localparam access_size_t SZ_H    = 4'b0010;
    localparam access_size_t SZ_W    = 4'b0100;
    localparam access_size_t SZ_D    = 4'b1000;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        instr_class_e        instr_class;
        logic                rd_v;
        logic [4:0]          rd;
        logic                rs1_v;
        logic [4:0]          rs1;
        logic                rs2_v;
        logic [4:0]          rs2;
        logic                rs2_is_imm;
        logic [XLEN_MAX-1:0] imm;
        logic                is_load;
        logic                is_store;
        logic                is_branch;
        access_size_t        access_size;
        logic                is_unsigned;
        logic                illegal;
    } dec_pkt_t;

    localparam int DEC_PKT_W = $bits(dec_pkt_t);

endpackage

// File: rtl/decode_stage_unit.sv
// Combinational RV32/RV64 instruction decoder producing one dec_pkt_t.
// Bits above XLEN in pc/imm are always zero.
module decode_unit
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]          instr_i,
    input  logic [XLEN-1:0]      pc_i,
    output logic [DEC_PKT_W-1:0] pkt_o,
    output logic                 illegal_o
);

    localparam bit RV64 = (XLEN == 64);
    localparam logic [XLEN_MAX-1:0] IMM_MASK = RV64 ? {XLEN_MAX{1'b1}} : 64'h0000_0000_FFFF_FFFF;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [XLEN_MAX-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    assign imm_i = {{52{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{52{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_j = {{44{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign imm_u = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};

    instr_class_e        cls;
    logic                legal, rd_v, rs1_v, rs2_v, r2i, ld, st, br, uns, rd_use;
    logic [XLEN_MAX-1:0] imm;
    access_size_t        sz;
    dec_pkt_t            pkt;

    always_comb begin
        cls   = CLS_NONE;
        legal = 1'b0;
        rd_v  = 1'b0;
        rs1_v = 1'b0;
        rs2_v = 1'b0;
        r2i   = 1'b0;
        imm   = '0;
        ld    = 1'b0;
        st    = 1'b0;
        br    = 1'b0;
        sz    = SZ_NONE;
        uns   = 1'b0;

        case (opcode)
            OPC_OP: begin
                cls = CLS_R; rd_v = 1'b1; rs1_v = 1'b1; rs2_v = 1'b1;
                legal = (funct7 == 7'b0000000) ||
                        (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                uns = (funct3 == 3'b011);
            end
            OPC_OP_IMM: begin
                cls = CLS_I; rd_v = 1'b1; rs1_v = 1'b1; r2i = 1'b1; imm = imm_i;
                uns = (funct3 == 3'b011);
                // RV64 shifts borrow funct7[0] as shamt[5].
                case (funct3)
                    3'b001:  legal = RV64 ? (funct7[6:1] == 6'b000000) : (funct7 == 7'b0000000);
                    3'b101:  legal = RV64 ? (funct7[6:1] == 6'b000000 || funct7[6:1] == 6'b010000)
                                          : (funct7 == 7'b0000000 || funct7 == 7'b0100000);
                    default: legal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                cls = CLS_L; rd_v = 1'b1; rs1_v = 1'b1; r2i = 1'b1; imm = imm_i; ld = 1'b1;
                case (funct3)
                    3'b000:  begin legal = 1'b1; sz = SZ_B; end
                    3'b001:  begin legal = 1'b1; sz = SZ_H; end
                    3'b010:  begin legal = 1'b1; sz = SZ_W; end
                    3'b011:  begin legal = RV64; sz = SZ_D; end
                    3'b100:  begin legal = 1'b1; sz = SZ_B; uns = 1'b1; end
                    3'b101:  begin legal = 1'b1; sz = SZ_H; uns = 1'b1; end
                    3'b110:  begin legal = RV64; sz = SZ_W; uns = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                cls = CLS_S; rs1_v = 1'b1; rs2_v = 1'b1; r2i = 1'b1; imm = imm_s; st = 1'b1;
                case (funct3)
                    3'b000:  begin legal = 1'b1; sz = SZ_B; end
                    3'b001:  begin legal = 1'b1; sz = SZ_H; end
                    3'b010:  begin legal = 1'b1; sz = SZ_W; end
                    3'b011:  begin legal = RV64; sz = SZ_D; end
                    default: legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                cls = CLS_B; rs1_v = 1'b1; rs2_v = 1'b1; imm = imm_b; br = 1'b1;
                legal = (funct3[2:1] != 2'b01);
                uns = (funct3[2:1] == 2'b11);
            end
            OPC_LUI: begin
                cls = CLS_U; rd_v = 1'b1; r2i = 1'b1; imm = imm_u; legal = 1'b1;
            end
            OPC_AUIPC: begin
                cls = CLS_AUIPC; rd_v = 1'b1; r2i = 1'b1; imm = imm_u; legal = 1'b1;
            end
            OPC_JAL: begin
                cls = CLS_JAL; rd_v = 1'b1; r2i = 1'b1; imm = imm_j; legal = 1'b1;
            end
            OPC_JALR: begin
                cls = CLS_JALR; rd_v = 1'b1; rs1_v = 1'b1; r2i = 1'b1; imm = imm_i;
                legal = (funct3 == 3'b000);
            end
            OPC_SYSTEM: begin
                // CSR ops write rd; the immediate forms carry a uimm in the rs1 slot.
                cls = CLS_SYSTEM; imm = imm_i;
                legal = (funct3 != 3'b100);
                rd_v  = (funct3 != 3'b000);
                rs1_v = (funct3 != 3'b000) && !funct3[2];
            end
            OPC_FENCE: begin
                cls = CLS_FENCE;
                legal = (funct3 == 3'b000 || funct3 == 3'b001);
            end
            OPC_OP_32: begin
                cls = CLS_R64; rd_v = 1'b1; rs1_v = 1'b1; rs2_v = 1'b1;
                legal = RV64 &&
                        ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b101)) ||
                         (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OP_IMM_32: begin
                cls = CLS_I64; rd_v = 1'b1; rs1_v = 1'b1; r2i = 1'b1; imm = imm_i;
                legal = RV64 &&
                        ((funct3 == 3'b000) ||
                         (funct3 == 3'b001 && funct7 == 7'b0000000) ||
                         (funct3 == 3'b101 && (funct7 == 7'b0000000 || funct7 == 7'b0100000)));
            end
            default: legal = 1'b0;
        endcase

        rd_use = rd_v && (instr_i[11:7] != 5'd0);

        pkt    = '0;
        pkt.pc = XLEN_MAX'(pc_i);
        if (!legal) begin
            pkt.illegal = 1'b1;
        end else begin
            pkt.instr_class = cls;
            pkt.rd_v        = rd_use;
            pkt.rd          = rd_use ? instr_i[11:7] : 5'd0;
            pkt.rs1_v       = rs1_v;
            pkt.rs1         = rs1_v ? instr_i[19:15] : 5'd0;
            pkt.rs2_v       = rs2_v;
            pkt.rs2         = rs2_v ? instr_i[24:20] : 5'd0;
            pkt.rs2_is_imm  = r2i;
            pkt.imm         = imm & IMM_MASK;
            pkt.is_load     = ld;
            pkt.is_store    = st;
            pkt.is_branch   = br;
            pkt.access_size = sz;
            pkt.is_unsigned = uns;
        end
    end

    assign pkt_o     = pkt;
    assign illegal_o = pkt.illegal;

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes fetch instructions into a small skid FIFO
// and presents packets in order to issue, with accept/illegal counters.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 if_valid_i,
    output logic                 if_ready_o,
    input  logic [31:0]          if_instr_i,
    input  logic [XLEN-1:0]      if_pc_i,
    output logic                 dec_valid_o,
    input  logic                 dec_ready_i,
    output logic [DEC_PKT_W-1:0] dec_pkt_o,
    output logic [CNT_W-1:0]     cnt_decoded_o,
    output logic [CNT_W-1:0]     cnt_illegal_o
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FILL_W = $clog2(DEPTH + 1);

    logic [DEC_PKT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]     cnt_dec_q, cnt_dec_d, cnt_ill_q, cnt_ill_d;
    logic [DEC_PKT_W-1:0] dec_pkt;
    logic                 dec_illegal, push, pop;

    decode_unit #(.XLEN(XLEN)) u_decode (
        .instr_i   (if_instr_i),
        .pc_i      (if_pc_i),
        .pkt_o     (dec_pkt),
        .illegal_o (dec_illegal)
    );

    // Both sides: a transfer happens on a clock edge where valid & ready are
    // high and flush_i is low. if_ready_o comes only from the registered fill
    // count, so there is no combinational path from dec_ready_i to fetch.
    assign if_ready_o  = (count_q < FILL_W'(DEPTH));
    assign dec_valid_o = (count_q != '0);
    assign dec_pkt_o   = dec_valid_o ? mem_q[rd_ptr_q] : '0;

    assign push = if_valid_i & if_ready_o & ~flush_i;
    assign pop  = dec_valid_o & dec_ready_i & ~flush_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        cnt_dec_d = cnt_dec_q;
        cnt_ill_d = cnt_ill_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                cnt_dec_d = cnt_dec_q + CNT_W'(1);
                if (dec_illegal) cnt_ill_d = cnt_ill_q + CNT_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + FILL_W'(1);
                2'b01:   count_d = count_q - FILL_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cnt_dec_q <= '0;
            cnt_ill_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            cnt_dec_q <= cnt_dec_d;
            cnt_ill_q <= cnt_ill_d;
        end
    end

    // Storage needs no reset: dec_pkt_o is gated to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= dec_pkt;
    end

    assign cnt_decoded_o = cnt_dec_q;
    assign cnt_illegal_o = cnt_ill_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an XLEN=32 and an XLEN=64 instance share one input
// stream; decoded packets are checked against a hand-written vector table.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = 32;
    localparam int NV    = 13;
    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic clk = 1'b0;
    logic rst, flush_i, if_valid_i, dec_ready_i;
    logic [31:0] if_instr_i, if_pc_i;
    logic ready32, ready64, valid32, valid64;
    logic [DEC_PKT_W-1:0] pkt32, pkt64;
    logic [CNT_W-1:0] cdec32, cill32, cdec64, cill64;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut32 (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .if_valid_i(if_valid_i), .if_ready_o(ready32),
        .if_instr_i(if_instr_i), .if_pc_i(if_pc_i),
        .dec_valid_o(valid32), .dec_ready_i(dec_ready_i), .dec_pkt_o(pkt32),
        .cnt_decoded_o(cdec32), .cnt_illegal_o(cill32)
    );

    decode_stage #(.XLEN(64), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut64 (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .if_valid_i(if_valid_i), .if_ready_o(ready64),
        .if_instr_i(if_instr_i), .if_pc_i({32'h0, if_pc_i}),
        .dec_valid_o(valid64), .dec_ready_i(dec_ready_i), .dec_pkt_o(pkt64),
        .cnt_decoded_o(cdec64), .cnt_illegal_o(cill64)
    );

    typedef struct {
        logic [31:0] instr;
        logic        ill32;
        dec_pkt_t    e64;
    } vec_t;

    vec_t tbl [NV];
    logic [7:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cur_idx = 0;
    logic [31:0] m_dec, m_ill32, m_ill64;

    function automatic dec_pkt_t mk(instr_class_e c, logic rdv, logic [4:0] rd,
                                    logic r1v, logic [4:0] r1, logic r2v, logic [4:0] r2,
                                    logic r2i, logic [63:0] imm, logic [2:0] lsb,
                                    logic [3:0] sz, logic uns);
        dec_pkt_t p;
        p = '0;
        p.instr_class = c;
        p.rd_v = rdv;   p.rd = rd;
        p.rs1_v = r1v;  p.rs1 = r1;
        p.rs2_v = r2v;  p.rs2 = r2;
        p.rs2_is_imm = r2i;
        p.imm = imm;
        {p.is_load, p.is_store, p.is_branch} = lsb;
        p.access_size = sz;
        p.is_unsigned = uns;
        return p;
    endfunction

    function automatic dec_pkt_t mk_ill();
        dec_pkt_t p;
        p = '0;
        p.illegal = 1'b1;
        return p;
    endfunction

    function automatic logic [31:0] pc_of(int idx);
        return 32'h8000_1000 + 32'(idx * 4);
    endfunction

    function automatic dec_pkt_t exp_pkt(int idx, bit is64);
        dec_pkt_t p;
        p = tbl[idx].e64;
        if (!is64) begin
            if (tbl[idx].ill32) p = mk_ill();
            p.imm[63:32] = '0;
        end
        p.pc = {32'h0, pc_of(idx)};
        return p;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_pkt(string name, logic [DEC_PKT_W-1:0] act, logic [DEC_PKT_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(int idx);
        cur_idx    = idx;
        if_instr_i = tbl[idx].instr;
        if_pc_i    = pc_of(idx);
        if_valid_i = 1'b1;
    endtask

    // Called at a falling edge with inputs already driven; checks, updates
    // the scoreboard for the coming rising edge, then advances one cycle.
    task automatic step(output logic acc);
        logic exp_rdy, exp_vld;
        int idx;
        #1;
        exp_rdy = (exp_q.size() < DEPTH);
        exp_vld = (exp_q.size() != 0);
        chk("if_ready32", ready32, exp_rdy);
        chk("if_ready64", ready64, exp_rdy);
        chk("dec_valid32", valid32, exp_vld);
        chk("dec_valid64", valid64, exp_vld);
        chk("cnt_decoded32", cdec32, m_dec);
        chk("cnt_decoded64", cdec64, m_dec);
        chk("cnt_illegal32", cill32, m_ill32);
        chk("cnt_illegal64", cill64, m_ill64);
        acc = 1'b0;
        if (flush_i) begin
            exp_q.delete();
        end else begin
            if (exp_vld && dec_ready_i) begin
                idx = int'(exp_q.pop_front());
                chk_pkt("pkt32", pkt32, exp_pkt(idx, 1'b0));
                chk_pkt("pkt64", pkt64, exp_pkt(idx, 1'b1));
            end
            if (if_valid_i && exp_rdy) begin
                exp_q.push_back(8'(cur_idx));
                m_dec   = m_dec + 1;
                m_ill32 = m_ill32 + 32'(exp_pkt(cur_idx, 1'b0).illegal);
                m_ill64 = m_ill64 + 32'(tbl[cur_idx].e64.illegal);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(int idx, bit rnd);
        logic acc;
        acc = 1'b0;
        set_in(idx);
        for (int k = 0; k < 20; k++) begin
            if (rnd) dec_ready_i = ($urandom_range(0, 3) != 0);
            step(acc);
            if (acc) break;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL offer_timeout: entry %0d not accepted within 20 cycles", idx);
        end
    endtask

    task automatic drain();
        logic acc;
        if_valid_i  = 1'b0;
        dec_ready_i = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(acc);
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d packets still expected", exp_q.size());
        end
    endtask

    task automatic do_reset();
        logic acc;
        rst = 1'b1; flush_i = 1'b0; if_valid_i = 1'b0; dec_ready_i = 1'b0;
        if_instr_i = '0; if_pc_i = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_dec = '0; m_ill32 = '0; m_ill64 = '0;
        #1;
        chk_pkt("reset_pkt32", pkt32, '0);
        chk_pkt("reset_pkt64", pkt64, '0);
        step(acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic [DEC_PKT_W-1:0] held;

        tbl[0]  = '{32'hFFF10093, N, mk(CLS_I,   Y, 5'd1, Y, 5'd2,  N, 5'd0, Y, 64'hFFFF_FFFF_FFFF_FFFF, 3'b000, 4'b0000, N)};
        tbl[1]  = '{32'hFE000EE3, N, mk(CLS_B,   N, 5'd0, Y, 5'd0,  Y, 5'd0, N, 64'hFFFF_FFFF_FFFF_FFFC, 3'b001, 4'b0000, N)};
        tbl[2]  = '{32'h0080B283, Y, mk(CLS_L,   Y, 5'd5, Y, 5'd1,  N, 5'd0, Y, 64'd8,                   3'b100, 4'b1000, N)};
        tbl[3]  = '{32'h00000013, N, mk(CLS_I,   N, 5'd0, Y, 5'd0,  N, 5'd0, Y, 64'd0,                   3'b000, 4'b0000, N)};
        tbl[4]  = '{32'h800001B7, N, mk(CLS_U,   Y, 5'd3, N, 5'd0,  N, 5'd0, Y, 64'hFFFF_FFFF_8000_0000, 3'b000, 4'b0000, N)};
        tbl[5]  = '{32'h002081B3, N, mk(CLS_R,   Y, 5'd3, Y, 5'd1,  Y, 5'd2, N, 64'd0,                   3'b000, 4'b0000, N)};
        tbl[6]  = '{32'h00512623, N, mk(CLS_S,   N, 5'd0, Y, 5'd2,  Y, 5'd5, Y, 64'd12,                  3'b010, 4'b0100, N)};
        tbl[7]  = '{32'hFFF54383, N, mk(CLS_L,   Y, 5'd7, Y, 5'd10, N, 5'd0, Y, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 4'b0001, Y)};
        tbl[8]  = '{32'h003100BB, Y, mk(CLS_R64, Y, 5'd1, Y, 5'd2,  Y, 5'd3, N, 64'd0,                   3'b000, 4'b0000, N)};
        tbl[9]  = '{32'h02111093, Y, mk(CLS_I,   Y, 5'd1, Y, 5'd2,  N, 5'd0, Y, 64'd33,                  3'b000, 4'b0000, N)};
        tbl[10] = '{32'hFF9FF0EF, N, mk(CLS_JAL, Y, 5'd1, N, 5'd0,  N, 5'd0, Y, 64'hFFFF_FFFF_FFFF_FFF8, 3'b000, 4'b0000, N)};
        tbl[11] = '{32'h0020E463, N, mk(CLS_B,   N, 5'd0, Y, 5'd1,  Y, 5'd2, N, 64'd8,                   3'b001, 4'b0000, Y)};
        tbl[12] = '{32'h00000000, Y, mk_ill()};

        do_reset();

        // Whole table with random backpressure.
        for (int i = 0; i < NV; i++) offer(i, 1'b1);
        drain();

        // Full FIFO: third offer held, head packet stable, then in-order release.
        dec_ready_i = 1'b0;
        offer(0, 1'b0);
        offer(1, 1'b0);
        set_in(4);
        held = pkt32;
        step(acc);
        chk_pkt("stall_stable_1", pkt32, held);
        step(acc);
        chk_pkt("stall_stable_2", pkt32, held);
        dec_ready_i = 1'b1;
        offer(4, 1'b0);
        drain();

        // Flush a full FIFO while fetch offers an instruction.
        dec_ready_i = 1'b0;
        offer(2, 1'b0);
        offer(3, 1'b0);
        set_in(12);
        flush_i = 1'b1;
        step(acc);
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        step(acc);
        step(acc);

        // Reset with packets in flight, then traffic resumes from zero.
        dec_ready_i = 1'b0;
        offer(5, 1'b0);
        offer(8, 1'b0);
        do_reset();
        dec_ready_i = 1'b1;
        offer(0, 1'b0);
        drain();
        if_valid_i = 1'b0;
        step(acc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised RV32/RV64 decode stage with a valid/ready handshake on both sides.
- Sits between fetch and issue. Accepts raw instructions with their PC and decodes them through a combinational sub-unit.
- Buffers decoded packets in a small skid FIFO and presents them in order to issue.
- Adds over the previous decoder: sign-extended XLEN immediates, XLEN-gated RV64 legality, x0-destination suppression, flush, backpressure, and decode/illegal event counters.

Parameters:
- XLEN, 32, datapath width; only 32 or 64 are legal. With 32, RV64-only encodings are illegal.
- DEPTH, 2, skid FIFO entries; minimum 2, power of two.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  discard all buffered packets and any input offered this cycle
- if_valid_i  in  1  fetch offers an instruction
- if_ready_o  out  1  stage can accept (count < DEPTH)
- if_instr_i  in  32  instruction word
- if_pc_i  in  XLEN  instruction PC
- dec_valid_o  out  1  head packet valid
- dec_ready_i  in  1  issue consumes head packet
- dec_pkt_o  out  $bits(dec_pkt_t)  decoded head packet (fields listed under Decomposition)
- cnt_decoded_o  out  CNT_W  packets accepted since reset
- cnt_illegal_o  out  CNT_W  illegal packets accepted since reset

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) values:
  - FIFO count 0; read/write pointers 0.
  - dec_valid_o 0, if_ready_o 1.
  - dec_pkt_o all zeros; counters 0.
  - Reset mid-transfer drops all in-flight packets.
- Accept and pop rules:
  - Accept when if_valid_i & if_ready_o & ~flush_i. The decoded packet is written at the write pointer.
  - Pop when dec_valid_o & dec_ready_i & ~flush_i.
- Latency: an instruction accepted at edge N into an empty FIFO drives dec_valid_o=1 with its packet from after edge N. One cycle, no bypass.
- if_ready_o depends only on registered count. There is no combinational path from dec_ready_i. When full, push and pop in the same cycle are not possible because if_ready_o=0.
- Push and pop in the same cycle when 0 < count < DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- dec_pkt_o holds stable while dec_valid_o=1 and dec_ready_i=0.
- flush_i=1: next cycle count=0 and dec_valid_o=0. The offered input is not accepted and does not count. Flush has priority over push and pop. Counters are not cleared.
- Decode rules:
  - Opcode/funct classes as today: R, I, L, S, B, U, AUIPC, JAL, JALR, SYSTEM, FENCE, plus R64/I64.
  - R64/I64, ld, lwu and sd are legal only when XLEN=64; otherwise illegal.
  - RV64 slli/srli/srai use a 6-bit shamt (funct7[6:1] checked).
- Immediates are sign-extended from bit 31 to XLEN:
  - I/L/JALR: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - U/AUIPC: {instr[31:12], 12'b0}.
- rs1/rs2/rd fields are taken from instr bits and zeroed when their valid bit is 0. rd_v is forced to 0 when rd==0.
- Illegal instructions are still enqueued, with illegal=1, all register valids 0 and imm 0. Issue raises the exception.
- access_size is one-hot: 4'b0001 byte, 0010 half, 0100 word, 1000 double; 0 for non-memory ops.
- unsigned is set for lbu/lhu/lwu/bltu/bgeu/sltu/sltiu.
- Counters increment by 1 per accepted packet (cnt_illegal_o only when illegal) and wrap silently at 2^CNT_W.

Decomposition:
- Package riscv gains:
  - instr_class_e (one-hot class enum, width 13).
  - access_size_t (4-bit).
  - dec_pkt_t struct: pc[XLEN], instr_class, rd_v, rd, rs1_v, rs1, rs2_v, rs2, rs2_is_imm, imm[XLEN], is_load, is_store, is_branch, access_size, unsigned, illegal.
  - Opcode constants for R64/I64/SYSTEM/FENCE.
- The struct is parameterised via the XLEN_MAX=64 package constant, with upper bits zero when XLEN=32.
- Sub-module: decode_unit. Purely combinational, parameter XLEN; inputs instr/pc, output dec_pkt_t. Tested standalone.

Test Plan:
- XLEN=32, addi x1,x2,-1 (0xFFF10093), dec_ready_i=1 -> one cycle later dec_valid_o=1, rd=1 rd_v=1, rs1=2 rs1_v=1, rs2_v=0, imm=0xFFFFFFFF, rs2_is_imm=1; cnt_decoded_o=1.
- beq x0,x0,-4 (0xFE000EE3) -> imm=0xFFFFFFFC, is_branch=1, rs1_v=rs2_v=1, rd_v=0.
- ld x5,8(x1) (0x0080B283): XLEN=32 -> illegal=1, cnt_illegal_o=1. XLEN=64 -> illegal=0, access_size=4'b1000, imm=8, is_load=1.
- Hold dec_ready_i=0 and offer 3 instrs back-to-back with DEPTH=2 -> if_ready_o drops after 2 accepts; third held. Release dec_ready_i -> packets emerge in order with no loss or duplication; dec_pkt_o stable while stalled.
- FIFO holding 2 packets, flush_i=1 with if_valid_i=1 -> next cycle dec_valid_o=0, if_ready_o=1, counters unchanged by the flushed input.
- addi x0,x0,0 (0x00000013) -> rd_v=0, rd=0; lui x3,0x80000 (0x800001B7) at XLEN=64 -> imm=0xFFFFFFFF80000000.
